// File: rtl/qdiv_serial.sv
// Serial restoring divider for Q/N sign-magnitude fixed point: c = a / b,
// one quotient bit per clock, start/done handshake, saturating on overflow or /0.
module qdiv_serial #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] c,
  output logic         ovr
);

  localparam int DW = N - 1 + Q;
  localparam int KW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_d;
  logic [DW-2:0] r_qr;
  logic [N-2:0]  r_r;
  logic [N-2:0]  r_bmag;
  logic          r_sgn;
  logic [KW-1:0] r_k;
  logic [N-1:0]  r_c;
  logic          r_ovr;

  logic [N-1:0]  w_r_shift;
  logic [N-2:0]  w_r_nxt;
  logic [DW-1:0] w_qr_nxt;
  logic          w_ge;
  logic          w_last;
  logic [N-1:0]  w_c_nxt;
  logic          w_ovr_nxt;

  // Remainder after subtraction is always below |b|, so N-1 bits hold it exactly.
  always_comb begin
    w_r_shift = {r_r, r_d[DW-1]};
    w_ge      = (w_r_shift >= {1'b0, r_bmag});
    w_r_nxt   = w_ge ? (w_r_shift[N-2:0] - r_bmag) : w_r_shift[N-2:0];
    w_qr_nxt  = {r_qr, w_ge};
    w_last    = (r_k == KW'(1));
  end

  always_comb begin
    w_c_nxt   = '0;
    w_ovr_nxt = 1'b0;
    if (r_bmag == '0) begin
      w_c_nxt   = {1'b0, {(N-1){1'b1}}};
      w_ovr_nxt = 1'b1;
    end else if (|w_qr_nxt[DW-1:N-1]) begin
      w_c_nxt   = {r_sgn, {(N-1){1'b1}}};
      w_ovr_nxt = 1'b1;
    end else begin
      // A zero magnitude never carries a sign, so -0 cannot appear on c.
      w_c_nxt   = {r_sgn & (|w_qr_nxt[N-2:0]), w_qr_nxt[N-2:0]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d    <= '0;
      r_qr   <= '0;
      r_r    <= '0;
      r_bmag <= '0;
      r_sgn  <= 1'b0;
      r_k    <= '0;
      r_c    <= '0;
      r_ovr  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_d    <= {a[N-2:0], {Q{1'b0}}};
      r_qr   <= '0;
      r_r    <= '0;
      r_bmag <= b[N-2:0];
      r_sgn  <= a[N-1] ^ b[N-1];
      r_k    <= KW'(DW);
    end else if (r_state == CALC) begin
      r_d  <= r_d << 1;
      r_qr <= w_qr_nxt[DW-2:0];
      r_r  <= w_r_nxt;
      r_k  <= r_k - KW'(1);
      if (w_last) begin
        r_c   <= w_c_nxt;
        r_ovr <= w_ovr_nxt;
      end
    end
  end

  assign busy = (r_state == CALC);
  assign done = (r_state == DONE);
  assign c    = r_c;
  assign ovr  = r_ovr;

endmodule
